piso_serializer: RTL
====================

Name: piso_serializer

Overview:
- Parallel-in/serial-out transmitter. Accepts a WIDTH-bit word through a valid/ready load handshake.
- Shifts the word out one bit per clock on a single serial line.
- Built to drive a flip-flop-based serial receiver / shift-register capture stage downstream.
- Supports back-to-back words with no idle gap.

Parameters:
- WIDTH, 8, data bits per word; legal range 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- load_valid  input  1  load_data valid this cycle
- load_data  input  WIDTH  word to transmit
- load_ready  output  1  serializer can accept a word this cycle
- sout  output  1  serial data bit (registered)
- sout_valid  output  1  sout carries a frame bit this cycle (registered)
- frame_start  output  1  high with the first bit of each frame (registered)
- done  output  1  high with the last bit of each frame (registered)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
  - While reset=1: state=IDLE; shift register, bit counter, sout, sout_valid, frame_start and done are all 0.
  - load_ready is forced to 0 while reset=1.
  - Reset mid-frame aborts the frame immediately. Remaining bits are discarded. There is no resume.
- States:
  - IDLE: sout=0, sout_valid=0, load_ready=1.
  - SHIFT: a frame is being sent.
- Handshake: a transfer occurs on a rising edge where load_valid=1 and load_ready=1.
  - load_data is sampled on that edge.
  - The upstream source must hold load_data stable while load_valid=1 and load_ready=0.
- Latency:
  - The first bit appears on sout in the cycle after the handshake edge (1 cycle).
  - Bits are presented in cycles 1..N after the handshake, where N=WIDTH (N=WIDTH+1 with parity; see Optional Feature).
- Counter: bit counter width is $clog2(WIDTH+1).
  - Loads 0 on handshake and increments per bit.
  - The frame ends when the counter reaches N-1.
  - Never wraps inside a frame.
- Flags:
  - frame_start=1 only in bit cycle 1.
  - done=1 only in bit cycle N.
  - sout_valid=1 in bit cycles 1..N.
  - For WIDTH>=2, frame_start and done are never high together.
- load_ready timing:
  - load_ready=1 in IDLE and during the last bit cycle (cycle N) of SHIFT.
  - load_ready=0 in all other SHIFT cycles.
- Transitions:
  - IDLE -> SHIFT on a transfer.
  - SHIFT -> SHIFT at end of frame if a new transfer occurs in cycle N. The next frame's bit 1 follows in the very next cycle, with frame_start=1 and no gap.
  - SHIFT -> IDLE at end of frame otherwise. sout returns to 0 and sout_valid to 0 on the following cycle.
- Bit order:
  - MSB_FIRST=1: load_data[WIDTH-1] down to load_data[0].
  - MSB_FIRST=0: load_data[0] up to load_data[WIDTH-1].
- Other boundary rules:
  - load_valid asserted while load_ready=0 has no effect; the word is not lost, the source keeps it asserted.
  - X/Z on load_data outside a transfer has no effect on outputs.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - One extra bit is appended after the data bits: even parity = XOR of all WIDTH data bits, computed at load.
  - N=WIDTH+1.
  - done and the load_ready window move to the parity cycle.
  - sout_valid=1 during the parity cycle.
- Undefined:
  - No parity bit; N=WIDTH; no parity logic is synthesized.

Test Plan:
1. Reset behaviour: reset=1 for 10 ns, then 0; load_valid=0. Required: sout=0, sout_valid=0, frame_start=0, done=0; load_ready=0 during reset and 1 after release.
2. Single frame, WIDTH=8, MSB_FIRST=1: load 8'hA5 with one-cycle load_valid. Required: cycles 1..8 sout = 1,0,1,0,0,1,0,1; frame_start in cycle 1; done in cycle 8; sout_valid=0 in cycle 9.
3. LSB first, MSB_FIRST=0: load 8'h01. Required: sout = 1,0,0,0,0,0,0,0; load_ready=0 in cycles 1..7 and 1 in cycle 8.
4. Back-to-back: hold load_valid=1 with 8'hFF, then present 8'h00 while load_ready=1 in cycle 8. Required: 16 contiguous sout_valid cycles, eight 1s then eight 0s; frame_start in cycles 1 and 9; done in cycles 8 and 16.
5. Reset mid-frame: load 8'hF0, then assert reset at bit cycle 3 for 10 ns. Required: sout and sout_valid go 0 asynchronously; after release the block is in IDLE and a new 8'h0F transmits cleanly from bit 1.
6. PISO_PARITY_EN defined: load 8'hA5 then 8'h07. Required: 9-bit frames; parity bit 0 for 8'hA5 and 1 for 8'h07; done in cycle 9 of each frame.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter with valid/ready load and back-to-back framing.
// Optional even-parity trailer bit is enabled by defining PISO_PARITY_EN.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             done
);

`ifdef PISO_PARITY_EN
    localparam int N = WIDTH + 1;
`else
    localparam int N = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]    state;
    logic [N-1:0]  shreg;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [N-1:0]  frame;
    logic          last;
    logic          xfer;
    logic          first_bit;
    logic          next_bit;
    logic [N-1:0]  frame_rest;
    logic [N-1:0]  shreg_rest;

    // Frame is the full bit sequence laid out so that shifting toward the
    // transmit end yields data bits followed by the optional parity bit.
    always_comb begin
        frame = '0;
`ifdef PISO_PARITY_EN
        if (MSB_FIRST != 0) begin
            frame = {load_data, ^load_data};
        end else begin
            frame = {^load_data, load_data};
        end
`else
        frame = load_data;
`endif
    end

    always_comb begin
        first_bit  = 1'b0;
        next_bit   = 1'b0;
        frame_rest = '0;
        shreg_rest = '0;
        if (MSB_FIRST != 0) begin
            first_bit  = frame[N-1];
            next_bit   = shreg[N-1];
            frame_rest = frame << 1;
            shreg_rest = shreg << 1;
        end else begin
            first_bit  = frame[0];
            next_bit   = shreg[0];
            frame_rest = frame >> 1;
            shreg_rest = shreg >> 1;
        end
    end

    assign cnt_next   = cnt + 1'b1;
    assign last       = (state == SHIFT) && (cnt == LAST);
    assign load_ready = !reset && ((state == IDLE) || last);
    assign xfer       = load_valid && load_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            shreg       <= '0;
            cnt         <= '0;
            sout        <= 1'b0;
            sout_valid  <= 1'b0;
            frame_start <= 1'b0;
            done        <= 1'b0;
        end else if (xfer) begin
            state       <= SHIFT;
            shreg       <= frame_rest;
            cnt         <= '0;
            sout        <= first_bit;
            sout_valid  <= 1'b1;
            frame_start <= 1'b1;
            done        <= 1'b0;
        end else if ((state == SHIFT) && !last) begin
            shreg       <= shreg_rest;
            cnt         <= cnt_next;
            sout        <= next_bit;
            sout_valid  <= 1'b1;
            frame_start <= 1'b0;
            done        <= (cnt_next == LAST);
        end else begin
            state       <= IDLE;
            cnt         <= '0;
            sout        <= 1'b0;
            sout_valid  <= 1'b0;
            frame_start <= 1'b0;
            done        <= 1'b0;
        end
    end

endmodule
